// File: rtl/mul16_seq_if.sv
// mul16_seq request/response bundle.
// master: start/a/b out, out/busy/done in; slave mirrors it.
interface mul16_seq_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] out;
  logic        busy;
  logic        done;

  modport master (
    output start, a, b,
    input  out, busy, done
  );

  modport slave (
    input  start, a, b,
    output out, busy, done
  );
endinterface

// File: rtl/mul16_seq.sv
// Sequential 16x16 shift-and-add multiplier, low 16 bits kept.
// Ports: clk, reset (sync, active-high), bus (start/a/b in, out/busy/done out).
module add16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o
);
  // Carry out of bit 15 is dropped.
  assign sum_o = a_i + b_i;
endmodule

module mul16_seq #(
  parameter int EARLY_EXIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  mul16_seq_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [15:0] mcand_q;
  logic [15:0] mreg_q;
  logic [15:0] acc_q;
  logic [15:0] out_q;
  logic [3:0]  count_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0] sum;
  logic [15:0] acc_d;
  logic        last;

  add16 u_add (
    .a_i   (acc_q),
    .b_i   (mcand_q),
    .sum_o (sum)
  );

  assign acc_d = mreg_q[0] ? sum : acc_q;

  // Stop when all 16 steps are done, or early when
  // no multiplier bits remain after this step.
  assign last = (count_q == 4'd15) ||
                ((EARLY_EXIT != 0) &&
                 (mreg_q[15:1] == 15'd0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      mreg_q  <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            mcand_q <= bus.a;
            mreg_q  <= bus.b;
            acc_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          mreg_q  <= mreg_q >> 1;
          count_q <= count_q + 4'd1;
          if (last) begin
            out_q   <= acc_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_mul16_seq.sv
// Randomised self-checking bench for mul16_seq.
// Checks both EARLY_EXIT builds against a product/latency model.
module tb_mul16_seq;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mul16_seq_if bus0 ();
  mul16_seq_if bus1 ();

  mul16_seq #(.EARLY_EXIT(1)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  mul16_seq #(.EARLY_EXIT(0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] last0 = '0;
  logic [15:0] last1 = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int steps(input logic [15:0] b,
                               input int ee);
    int hi;
    if (ee == 0) return 16;
    hi = 0;
    for (int i = 0; i < 16; i++)
      if (b[i]) hi = i + 1;
    return (hi == 0) ? 1 : hi;
  endfunction

  function automatic logic [15:0] prod(input logic [15:0] a,
                                       input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    return p[15:0];
  endfunction

  function automatic logic rd_busy(input int w);
    return (w == 0) ? bus0.busy : bus1.busy;
  endfunction

  function automatic logic rd_done(input int w);
    return (w == 0) ? bus0.done : bus1.done;
  endfunction

  function automatic logic [15:0] rd_out(input int w);
    return (w == 0) ? bus0.out : bus1.out;
  endfunction

  task automatic drive(input int w, input logic s,
                       input logic [15:0] a,
                       input logic [15:0] b);
    if (w == 0) begin
      bus0.start = s; bus0.a = a; bus0.b = b;
    end else begin
      bus1.start = s; bus1.a = a; bus1.b = b;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction: latency, pulse shape, result,
  // out stability and operand capture.
  task automatic do_mul(input int w, input logic [15:0] a,
                        input logic [15:0] b,
                        input string tag);
    int k;
    int cyc;
    bit bad;
    logic [15:0] e;
    logic [15:0] last;
    k = steps(b, (w == 0) ? 1 : 0);
    e = prod(a, b);
    last = (w == 0) ? last0 : last1;
    drive(w, 1'b1, a, b);
    tick;
    cyc = 0;
    bad = 1'b0;
    while (rd_busy(w) && cyc < 40) begin
      cyc++;
      if (rd_done(w) || rd_out(w) !== last) bad = 1'b1;
      drive(w, 1'b0, 16'($urandom), 16'($urandom));
      tick;
    end
    chk({tag, "_k"}, cyc, k);
    chk({tag, "_run"}, {31'd0, bad}, 0);
    chk({tag, "_done"}, {31'd0, rd_done(w)}, 1);
    chk({tag, "_busy"}, {31'd0, rd_busy(w)}, 0);
    chk({tag, "_out"}, {16'd0, rd_out(w)}, {16'd0, e});
    if (w == 0) last0 = e; else last1 = e;
    tick;
    chk({tag, "_pulse"}, {31'd0, rd_done(w)}, 0);
    chk({tag, "_idle"}, {31'd0, rd_busy(w)}, 0);
    chk({tag, "_hold"}, {16'd0, rd_out(w)}, {16'd0, e});
  endtask

  initial begin
    int dn;
    int acc_t;
    int prev_done;
    int t;
    logic pb;
    logic [15:0] ca, cb, da, db, m;
    logic [15:0] exp_o;
    reset = 1'b1;
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    tick;
    tick;
    chk("rst_out0", {16'd0, bus0.out}, 0);
    chk("rst_busy0", {31'd0, bus0.busy}, 0);
    chk("rst_done0", {31'd0, bus0.done}, 0);
    chk("rst_out1", {16'd0, bus1.out}, 0);
    reset = 1'b0;
    tick;

    do_mul(0, 16'd3, 16'd5, "m3x5");
    do_mul(0, 16'h00FF, 16'h0101, "mff");
    do_mul(0, 16'hFFFF, 16'hFFFF, "mwrap");
    do_mul(0, 16'h1234, 16'h0000, "mzero");
    do_mul(0, 16'h0001, 16'h8000, "mmsb");

    for (int i = 0; i < 40; i++) begin
      m = 16'((32'd1 << $urandom_range(0, 16)) - 1);
      do_mul(0, 16'($urandom), 16'($urandom) & m, "rnd");
    end

    // start held high with new operands during RUN
    drive(0, 1'b1, 16'd7, 16'd9);
    tick;
    drive(0, 1'b1, 16'd2, 16'd2);
    dn = 0;
    exp_o = 16'h0;
    for (int i = 0; i < 12; i++) begin
      if (bus0.done) begin
        dn++;
        exp_o = bus0.out;
        drive(0, 1'b0, 16'd2, 16'd2);
      end
      tick;
    end
    chk("hold_pulses", dn, 1);
    chk("hold_out", {16'd0, exp_o}, 32'h3F);
    chk("hold_idle", {31'd0, bus0.busy}, 0);
    last0 = 16'h003F;

    // reset during the third RUN cycle
    do_mul(0, 16'd3, 16'd5, "pre");
    drive(0, 1'b1, 16'h0100, 16'h00FF);
    tick;
    drive(0, 1'b0, '0, '0);
    tick;
    tick;
    chk("mid_busy", {31'd0, bus0.busy}, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mr_busy", {31'd0, bus0.busy}, 0);
    chk("mr_done", {31'd0, bus0.done}, 0);
    chk("mr_out", {16'd0, bus0.out}, 0);
    last0 = '0;
    last1 = '0;
    tick;
    chk("mr_idle", {31'd0, bus0.busy}, 0);
    do_mul(0, 16'h0100, 16'h00FF, "after_rst");

    // fixed 16-step build
    do_mul(1, 16'd3, 16'd5, "f3x5");
    for (int i = 0; i < 4; i++)
      do_mul(1, 16'($urandom), 16'($urandom), "frnd");

    // back-to-back requests every cycle
    pb = bus1.busy;
    da = 16'($urandom);
    db = 16'($urandom);
    ca = '0;
    cb = '0;
    acc_t = -1;
    prev_done = -1;
    dn = 0;
    for (t = 0; t < 80; t++) begin
      drive(1, 1'b1, da, db);
      tick;
      if (bus1.busy && !pb) begin
        ca = da;
        cb = db;
        acc_t = t;
      end
      if (bus1.done) begin
        dn++;
        chk("b2b_out", {16'd0, bus1.out},
            {16'd0, prod(ca, cb)});
        chk("b2b_lat", t - acc_t, 16);
        if (prev_done >= 0)
          chk("b2b_gap", t - prev_done, 18);
        prev_done = t;
      end
      pb = bus1.busy;
      da = 16'($urandom);
      db = 16'($urandom);
    end
    drive(1, 1'b0, '0, '0);
    chk("b2b_count", dn, 4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mul16_seq.md
Name: mul16_seq

Overview:
- Sequential unsigned 16x16 shift-and-add multiplier for the Hack-style datapath. It sits directly downstream of add16 and consumes it as its only adder.
- Result is the low 16 bits of the product, modulo 2^16, matching add16 carry-drop semantics.
- A start/busy/done handshake lets a controller or ALU extension issue one multiply at a time.

Parameters:
- EARLY_EXIT, 1: 1 = stop iterating once remaining multiplier bits are zero; 0 = always run 16 iterations.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  16  multiplicand; captured when start is accepted
- b  input  16  multiplier; captured when start is accepted
- out  output  16  (a*b) mod 2^16; holds last result until next completion
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, high in DONE

Behaviour:
- Reset (sampled at rising edge while reset=1) forces state=IDLE, out=0, busy=0, done=0, internal mcand/mreg/acc/count=0.
  - Reset overrides start and any in-flight RUN. The partial result is discarded and out does not update.
- Registers:
  - mcand[15:0]: shifted multiplicand.
  - mreg[15:0]: shifted multiplier.
  - acc[15:0]: accumulator.
  - count[3:0]: iteration counter.
- All accumulation uses one add16 instance: acc + mcand, carry dropped.
- States:
  - IDLE:
    - busy=0, done=0.
    - On an edge with start=1: mcand<=a, mreg<=b, acc<=0, count<=0, go RUN.
    - start=0: stay.
  - RUN: busy=1. Each edge performs one step:
    - acc <= mreg[0] ? add16(acc, mcand) : acc.
    - mcand <= mcand<<1, zero fill, MSB lost.
    - mreg <= mreg>>1.
    - count <= count+1.
  - RUN exits to DONE on the same edge when count==15, or when EARLY_EXIT=1 and mreg[15:1]==0.
    - On that edge out <= the step's new acc value.
  - DONE:
    - done=1, busy=0.
    - Next edge goes to IDLE unconditionally; start in DONE is ignored.
- Latency: k = number of RUN steps.
  - EARLY_EXIT=1: k = max(1, index of highest set bit of b + 1).
  - EARLY_EXIT=0: k = 16.
  - If start is accepted at edge E, then busy=1 after edges E..E+k-1, done=1 and out valid after edge E+k, and IDLE after edge E+k+1.
  - Minimum issue interval is k+2 cycles.
- b=0: exactly one RUN step (EARLY_EXIT=1), out=0.
- start while busy or done is ignored; a/b changes during RUN have no effect (operands captured at accept).
- out changes only on the final RUN edge or on reset. It is stable during RUN and IDLE.
- busy and done are never high simultaneously.

Test Plan:
- Reset, then a=3, b=5, start pulse 1 cycle -> busy high 3 cycles, done pulse 1 cycle, out=0x000F, then IDLE.
- a=0x00FF, b=0x0101 -> 9 RUN cycles, out=0xFFFF. Then a=0xFFFF, b=0xFFFF -> 16 RUN cycles, out=0x0001 (wrap mod 2^16).
- a=0x1234, b=0x0000 -> 1 RUN cycle, out=0x0000. Then a=0x0001, b=0x8000 -> 16 RUN cycles, out=0x8000.
- During RUN of 7*9, hold start=1 and change a/b to 2*2 -> exactly one done pulse with out=0x003F.
  - The second request is not started until start is reasserted in IDLE.
- Reset asserted on 3rd RUN cycle of 0x0100*0x00FF (previous out=0x000F) -> next cycle IDLE, busy=0, done=0, out=0x0000.
  - New start then completes normally.
- EARLY_EXIT=0 build, a=3, b=5 -> busy high 16 cycles, out=0x000F. Back-to-back starts issued every cycle are accepted every 18 cycles.
